// File: rtl/y_rr_mux.sv
// y_rr_mux: round-robin arbitrated, single-entry registered N:1 mux with valid/ready on both sides.
// Define Y_RR_MUX_COUNT_EN to add the 16-bit completed-transfer counter on xfer_count.
module y_rr_mux #(
    parameter int SIZE = 32,
    parameter int CH   = 4,
    parameter int SELW = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH*SIZE-1:0]  in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    output logic [SIZE-1:0]     out_data,
    output logic [SELW-1:0]     out_sel,
    output logic                out_valid,
    input  logic                out_ready
`ifdef Y_RR_MUX_COUNT_EN
    ,
    output logic [15:0]         xfer_count
`endif
);

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
        if (idx == SELW'(CH - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Walk the channels starting at 'start', wrapping, and return the first requester.
    function automatic logic [SELW-1:0] rr_pick(input logic [SELW-1:0] start,
                                                input logic [CH-1:0]   req);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] pick;
        logic            found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    logic [SELW-1:0] ptr_p1;
    logic [SELW-1:0] grant_p0;
    logic            load_p0;
    logic [SIZE-1:0] word_p0;
    logic [SIZE-1:0] data_p1;
    logic [SELW-1:0] sel_p1;
    logic            vld_p1;

    // Stage p0: arbitration and input select, all combinational.
    assign load_p0  = !reset && (!vld_p1 || out_ready) && (|in_valid);
    assign grant_p0 = rr_pick(ptr_p1, in_valid);
    assign in_ready = load_p0 ? (CH'(1) << grant_p0) : '0;

    always_comb begin
        word_p0 = '0;
        for (int k = 0; k < CH; k++) begin
            if (grant_p0 == SELW'(k)) begin
                word_p0 = in_data[k*SIZE +: SIZE];
            end
        end
    end

    // Stage p1: output register; the pointer only moves past a channel that was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr_p1  <= '0;
        end else if (load_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= word_p0;
            sel_p1  <= grant_p0;
            ptr_p1  <= wrap_inc(grant_p0);
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

`ifdef Y_RR_MUX_COUNT_EN
    logic [15:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else if (vld_p1 && out_ready) begin
            cnt_p1 <= cnt_p1 + 16'd1;
        end
    end

    assign xfer_count = cnt_p1;
`endif

endmodule

// File: doc/y_rr_mux.md
Y_RR_MUX -- requirements
Module: y_rr_mux

Interface
REQ-001 Parameter: SIZE, default 32, data width of every channel and of the output.
REQ-002 Parameter: CH, default 4, number of input channels (2..16).
REQ-003 Parameter: SELW, default 2, width of the channel index (ceil(log2(CH))).
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_data  input  CH*SIZE  channel k occupies bits [k*SIZE +: SIZE].
REQ-007 Port: in_valid  input  CH  channel k offers a word.
REQ-008 Port: in_ready  output  CH  channel k's word is accepted this cycle (combinational).
REQ-009 Port: out_data  output  SIZE  registered selected word.
REQ-010 Port: out_sel  output  SELW  registered index of the channel that supplied out_data.
REQ-011 Port: out_valid  output  1  out_data/out_sel hold a word.
REQ-012 Port: out_ready  input  1  consumer takes the word when out_valid is also 1.
REQ-013 Port (only with Y_RR_MUX_COUNT_EN): xfer_count  output  16  count of completed output transfers.

Function
REQ-014 Block SHALL be an N-way, round-robin-arbitrated 1-entry registered mux with valid/ready handshakes on both sides.
REQ-015 load = (!out_valid || out_ready) && (|in_valid).
REQ-016 Grant g SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ... and wrapping modulo CH.
REQ-017 in_ready[g] SHALL be 1 only when load=1; every other in_ready bit SHALL be 0.
REQ-018 On load, the next edge SHALL set out_data=in_data[g], out_sel=g and out_valid=1, with ptr=(g+1) mod CH (wraps CH-1 -> 0).
REQ-019 Latency: input accept to out_valid SHALL be exactly 1 cycle.
REQ-020 When out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold, all in_ready SHALL be 0, and ptr SHALL hold.
REQ-021 Drain with refill: out_valid && out_ready && load SHALL load the new word on the same edge (throughput 1 word/cycle, no bubble).
REQ-022 Drain without refill: out_valid && out_ready with no in_valid SHALL clear out_valid; out_data and out_sel SHALL keep their last values.
REQ-023 in_valid de-asserting without a grant SHALL be legal and SHALL have no effect on state.
REQ-024 Single requester SHALL be granted every cycle it is valid and not back-pressured.
REQ-025 Fairness: with all CH channels continuously valid, grants SHALL cycle through 0,1,...,CH-1 in order.

Reset
REQ-026 While reset=1 at an edge: out_valid=0, out_data=0, out_sel=0, ptr=0, xfer_count=0.
REQ-027 During reset cycles all in_ready SHALL be 0.
REQ-028 Reset mid-operation SHALL discard any held word without a transfer.
REQ-029 The first grant after reset SHALL search from channel 0.

Configuration
REQ-030 Macro Y_RR_MUX_COUNT_EN defined: xfer_count port present; it increments by 1 on each edge with out_valid && out_ready, wrapping 16'hFFFF -> 0.
REQ-031 Macro Y_RR_MUX_COUNT_EN undefined: xfer_count port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset: assert reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
REQ-033 Round-robin (CH=4): all valid with data k=32'h1000+k, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles with matching data and no bubbles.
REQ-034 Back-pressure: hold out_ready=0 for 3 cycles after a word from ch2 (32'hDEADBEEF) -> out_data/out_sel stable, in_ready=0; on release, the next grant is from ch3 (or the next valid after it).
REQ-035 Wrap and skip: ptr=3, only ch1 valid -> grant ch1, ptr becomes 2.
REQ-036 Randomised (500 iterations, $random data, valid and ready): scoreboard of accepted words in order -> out_data/out_sel match, no loss or duplication; with Y_RR_MUX_COUNT_EN, xfer_count equals the number of handshakes.
REQ-037 Reset mid-stall: reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, and the held word is never delivered.
